// File: rtl/io_input_sequencer.sv
// Debounced decimal keypad entry for the CPU IN path: up to MAX_DIGITS digits, enter/clear keys, BCD display.
// Optional macro IO_ECHO_EN: BCD outputs echo the live accumulator while an entry is in progress.
module io_input_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_DIGITS      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_req,
   input  logic [3:0]  switches,
   input  logic        button,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        stall,
   output logic        led_in,
   output logic        overflow,
   output logic [3:0]  bcd_uni,
   output logic [3:0]  bcd_dez,
   output logic [3:0]  bcd_cen
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [1:0]       MAX_CNT  = 2'(MAX_DIGITS);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } state_t;

   // Shift-and-add-3 conversion; values never exceed 999 so three digits suffice.
   function automatic logic [11:0] bin_to_bcd(input logic [9:0] bin);
      logic [11:0] bcd;
      bcd = 12'd0;
      for (int i = 9; i >= 0; i--) begin
         bcd[3:0]  = (bcd[3:0]  > 4'd4) ? (bcd[3:0]  + 4'd3) : bcd[3:0];
         bcd[7:4]  = (bcd[7:4]  > 4'd4) ? (bcd[7:4]  + 4'd3) : bcd[7:4];
         bcd[11:8] = (bcd[11:8] > 4'd4) ? (bcd[11:8] + 4'd3) : bcd[11:8];
         bcd       = {bcd[10:0], bin[i]};
      end
      return bcd;
   endfunction

   logic             btn_meta_q, btn_sync_q;
   logic [3:0]       sw_meta_q, sw_sync_q;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             btn_filt_q, btn_filt_d;
   logic             press_s;
   state_t           state_q, state_d;
   logic [9:0]       acc_q, acc_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             overflow_q, overflow_d;
   logic [9:0]       data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             stall_q, stall_d;
   logic             led_in_q, led_in_d;
   logic [9:0]       disp_s;
   logic [11:0]      bcd_q, bcd_d;

   // Two-flop synchronizers for the asynchronous button and switch bank.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         sw_meta_q  <= 4'd0;
         sw_sync_q  <= 4'd0;
      end else begin
         btn_meta_q <= button;
         btn_sync_q <= btn_meta_q;
         sw_meta_q  <= switches;
         sw_sync_q  <= sw_meta_q;
      end
   end

   // Debounce: count consecutive samples that disagree with the filtered level.
   always_comb begin
      deb_cnt_d  = CNT_ZERO;
      btn_filt_d = btn_filt_q;
      if (btn_sync_q != btn_filt_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            btn_filt_d = btn_sync_q;
            deb_cnt_d  = CNT_ZERO;
         end else begin
            deb_cnt_d  = deb_cnt_q + CNT_ONE;
         end
      end else begin
         deb_cnt_d = CNT_ZERO;
      end
   end

   assign press_s = btn_filt_d & ~btn_filt_q;

   // Entry FSM: next state, accumulator update and registered output values.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      overflow_d   = overflow_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            // A still-held button from the previous entry must release first.
            if (in_req && !btn_filt_q) begin
               state_d    = WAIT_PRESS;
               acc_d      = 10'd0;
               cnt_d      = 2'd0;
               overflow_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_PRESS: begin
            if (!in_req) begin
               state_d = IDLE;
            end else if (press_s) begin
               state_d = WAIT_RELEASE;
               case (sw_sync_q)
                  4'hE: begin
                     acc_d      = 10'd0;
                     cnt_d      = 2'd0;
                     overflow_d = 1'b0;
                  end
                  4'hF: begin
                     state_d      = DONE;
                     data_out_d   = acc_q;
                     data_valid_d = 1'b1;
                  end
                  default: begin
                     if (sw_sync_q <= 4'd9) begin
                        if (cnt_q < MAX_CNT) begin
                           acc_d = (acc_q * 10'd10) + {6'd0, sw_sync_q};
                           cnt_d = cnt_q + 2'd1;
                        end else begin
                           overflow_d = 1'b1;
                        end
                     end else begin
                        acc_d = acc_q;
                     end
                  end
               endcase
            end else begin
               state_d = WAIT_PRESS;
            end
         end
         WAIT_RELEASE: begin
            if (!in_req) begin
               state_d = IDLE;
            end else if (!btn_filt_q) begin
               state_d = WAIT_PRESS;
            end else begin
               state_d = WAIT_RELEASE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      stall_d  = (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
      led_in_d = stall_d;
   end

   // Source of the seven-segment digits.
   always_comb begin
`ifdef IO_ECHO_EN
      if ((state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE)) begin
         disp_s = acc_q;
      end else begin
         disp_s = data_out_q;
      end
`else
      disp_s = data_out_q;
`endif
      bcd_d = bin_to_bcd(disp_s);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_cnt_q    <= CNT_ZERO;
         btn_filt_q   <= 1'b0;
         state_q      <= IDLE;
         acc_q        <= 10'd0;
         cnt_q        <= 2'd0;
         overflow_q   <= 1'b0;
         data_out_q   <= 10'd0;
         data_valid_q <= 1'b0;
         stall_q      <= 1'b0;
         led_in_q     <= 1'b0;
         bcd_q        <= 12'd0;
      end else begin
         deb_cnt_q    <= deb_cnt_d;
         btn_filt_q   <= btn_filt_d;
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         overflow_q   <= overflow_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         stall_q      <= stall_d;
         led_in_q     <= led_in_d;
         bcd_q        <= bcd_d;
      end
   end

   assign data_out   = {22'd0, data_out_q};
   assign data_valid = data_valid_q;
   assign stall      = stall_q;
   assign led_in     = led_in_q;
   assign overflow   = overflow_q;
   assign bcd_cen    = bcd_q[11:8];
   assign bcd_dez    = bcd_q[7:4];
   assign bcd_uni    = bcd_q[3:0];

endmodule

// File: tb/tb_io_input_sequencer.sv
// Self-checking bench for io_input_sequencer: directed scenarios plus randomized entries against a key-level model.
module tb_io_input_sequencer;

   localparam int DEB  = 4;
   localparam int HOLD = DEB + 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_req = 1'b0;
   logic [3:0]  switches = 4'd0;
   logic        button = 1'b0;
   logic [31:0] data_out;
   logic        data_valid;
   logic        stall;
   logic        led_in;
   logic        overflow;
   logic [3:0]  bcd_uni, bcd_dez, bcd_cen;

   int tests = 0;
   int fails = 0;

   int          valid_cnt = 0;
   logic [31:0] last_val = 32'd0;
   logic        stall_at_valid = 1'b1;
   int          valid_run = 0;
   int          max_run = 0;

   // model state (key-level rules)
   int m_acc, m_cnt, m_data;
   bit m_ovf;

   io_input_sequencer #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(3)) dut (
      .clk(clk), .reset(reset), .in_req(in_req), .switches(switches), .button(button),
      .data_out(data_out), .data_valid(data_valid), .stall(stall), .led_in(led_in),
      .overflow(overflow), .bcd_uni(bcd_uni), .bcd_dez(bcd_dez), .bcd_cen(bcd_cen)
   );

   always #5 clk = ~clk;

   // Pulse monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         valid_cnt      <= valid_cnt + 1;
         last_val       <= data_out;
         stall_at_valid <= stall;
         valid_run      <= valid_run + 1;
         if (valid_run + 1 > max_run) max_run <= valid_run + 1;
      end else begin
         valid_run <= 0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full key press and release; the CPU drops in_req as soon as it sees data_valid.
   task automatic press_key(input logic [3:0] k);
      switches = k;
      cyc(3);
      button = 1'b1;
      for (int i = 0; i < HOLD; i++) begin
         cyc(1);
         if (data_valid === 1'b1) in_req = 1'b0;
      end
      button = 1'b0;
      cyc(HOLD);
   endtask

   task automatic model_clear();
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
   endtask

   task automatic model_key(input int k);
      if (k <= 9) begin
         if (m_cnt < 3) begin
            m_acc = m_acc * 10 + k;
            m_cnt = m_cnt + 1;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (k == 14) begin
         model_clear();
      end else if (k == 15) begin
         m_data = m_acc;
      end
   endtask

   function automatic logic [11:0] digits(input int v);
      logic [3:0] c, d, u;
      c = 4'((v / 100) % 10);
      d = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {c, d, u};
   endfunction

   task automatic test_reset();
      cyc(2);
      tests++;
      if ({data_out, data_valid, stall, led_in, overflow, bcd_cen, bcd_dez, bcd_uni} !== 44'd0) begin
         fails++;
         $display("FAIL reset_idle: outputs=%h expected all zero", {data_out, data_valid, stall, led_in, overflow, bcd_cen, bcd_dez, bcd_uni});
      end
      reset = 1'b0;
      cyc(2);
      in_req = 1'b1;
      cyc(1);
      press_key(4'd4);
      press_key(4'd2);
      tests++;
      if (stall !== 1'b1) begin
         fails++;
         $display("FAIL reset_pre_stall: stall=%b expected 1", stall);
      end
      reset = 1'b1;
      cyc(1);
      tests++;
      if ({data_out, data_valid, stall, led_in, overflow, bcd_cen, bcd_dez, bcd_uni} !== 44'd0) begin
         fails++;
         $display("FAIL reset_mid_entry: outputs=%h expected all zero", {data_out, data_valid, stall, led_in, overflow, bcd_cen, bcd_dez, bcd_uni});
      end
      in_req = 1'b0;
      reset = 1'b0;
      cyc(1);
      tests++;
      if ({data_out, stall, led_in, bcd_cen, bcd_dez, bcd_uni} !== 47'd0) begin
         fails++;
         $display("FAIL reset_release: data_out=%0d stall=%b led=%b bcd=%h expected zero", data_out, stall, led_in, {bcd_cen, bcd_dez, bcd_uni});
      end
   endtask

   task automatic test_basic_entry();
      int v0;
      v0 = valid_cnt;
      in_req = 1'b1;
      tests++;
      if (stall !== 1'b0) begin
         fails++;
         $display("FAIL stall_idle: stall=%b expected 0", stall);
      end
      cyc(1);
      tests++;
      if ({stall, led_in} !== 2'b11) begin
         fails++;
         $display("FAIL stall_rise: stall=%b led=%b expected 1 1", stall, led_in);
      end
      press_key(4'd1);
      press_key(4'd2);
      press_key(4'd3);
      press_key(4'hF);
      cyc(2);
      tests++;
      if (valid_cnt - v0 != 1) begin
         fails++;
         $display("FAIL basic_valid_count: got %0d pulses expected 1", valid_cnt - v0);
      end
      tests++;
      if (data_out !== 32'd123 || last_val !== 32'd123) begin
         fails++;
         $display("FAIL basic_data: data_out=%0d at_valid=%0d expected 123", data_out, last_val);
      end
      tests++;
      if (stall_at_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_stall_done: stall=%b in DONE cycle expected 0", stall_at_valid);
      end
      tests++;
      if ({bcd_cen, bcd_dez, bcd_uni} !== 12'h123) begin
         fails++;
         $display("FAIL basic_bcd: bcd=%h expected 123", {bcd_cen, bcd_dez, bcd_uni});
      end
   endtask

   task automatic test_overflow();
      int v0;
      v0 = valid_cnt;
      in_req = 1'b1;
      cyc(1);
      press_key(4'd9);
      press_key(4'd8);
      press_key(4'd7);
      press_key(4'd6);
      tests++;
      if (overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_set: overflow=%b expected 1", overflow);
      end
      press_key(4'hF);
      cyc(2);
      tests++;
      if (data_out !== 32'd987 || valid_cnt - v0 != 1) begin
         fails++;
         $display("FAIL ovf_data: data_out=%0d pulses=%0d expected 987 and 1", data_out, valid_cnt - v0);
      end
      v0 = valid_cnt;
      in_req = 1'b1;
      cyc(2);
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_new_entry: overflow=%b expected 0", overflow);
      end
      press_key(4'hE);
      press_key(4'd5);
      press_key(4'hF);
      cyc(2);
      tests++;
      if (data_out !== 32'd5 || overflow !== 1'b0 || valid_cnt - v0 != 1) begin
         fails++;
         $display("FAIL clear_entry: data_out=%0d ovf=%b pulses=%0d expected 5 0 1", data_out, overflow, valid_cnt - v0);
      end
   endtask

   task automatic test_bounce();
      logic [5:0] pat;
      int v0;
      v0 = valid_cnt;
      pat = 6'b111101;
      in_req = 1'b1;
      cyc(1);
      switches = 4'd2;
      cyc(3);
      button = 1'b1;
      cyc(DEB - 1);
      button = 1'b0;
      cyc(HOLD);
      switches = 4'd7;
      cyc(3);
      for (int i = 0; i < 6; i++) begin
         button = pat[i];
         cyc(1);
      end
      cyc(100);
      tests++;
      if ({stall, led_in} !== 2'b11) begin
         fails++;
         $display("FAIL bounce_hold_stall: stall=%b led=%b expected 1 1", stall, led_in);
      end
      button = 1'b0;
      cyc(HOLD);
      press_key(4'hF);
      cyc(2);
      tests++;
      if (data_out !== 32'd7 || valid_cnt - v0 != 1) begin
         fails++;
         $display("FAIL bounce_data: data_out=%0d pulses=%0d expected 7 and 1", data_out, valid_cnt - v0);
      end
   endtask

   task automatic test_empty_and_ignored();
      int v0;
      v0 = valid_cnt;
      in_req = 1'b1;
      cyc(1);
      press_key(4'hF);
      cyc(2);
      tests++;
      if (data_out !== 32'd0 || valid_cnt - v0 != 1) begin
         fails++;
         $display("FAIL empty_enter: data_out=%0d pulses=%0d expected 0 and 1", data_out, valid_cnt - v0);
      end
      v0 = valid_cnt;
      in_req = 1'b1;
      cyc(1);
      press_key(4'd3);
      press_key(4'd11);
      press_key(4'hF);
      cyc(2);
      tests++;
      if (data_out !== 32'd3 || valid_cnt - v0 != 1) begin
         fails++;
         $display("FAIL ignored_key: data_out=%0d pulses=%0d expected 3 and 1", data_out, valid_cnt - v0);
      end
   endtask

   task automatic test_abort();
      int v0;
      logic [11:0] exp_bcd;
      in_req = 1'b1;
      cyc(1);
      press_key(4'd1);
      press_key(4'd2);
      press_key(4'd3);
      press_key(4'hF);
      cyc(2);
      v0 = valid_cnt;
      in_req = 1'b1;
      cyc(1);
      press_key(4'd4);
      press_key(4'd5);
`ifdef IO_ECHO_EN
      exp_bcd = 12'h045;
`else
      exp_bcd = 12'h123;
`endif
      tests++;
      if ({bcd_cen, bcd_dez, bcd_uni} !== exp_bcd) begin
         fails++;
         $display("FAIL abort_display: bcd=%h expected %h", {bcd_cen, bcd_dez, bcd_uni}, exp_bcd);
      end
      in_req = 1'b0;
      cyc(3);
      press_key(4'd6);
      tests++;
      if (stall !== 1'b0 || led_in !== 1'b0 || valid_cnt != v0 || data_out !== 32'd123) begin
         fails++;
         $display("FAIL abort_state: stall=%b led=%b pulses=%0d data_out=%0d expected 0 0 0 123", stall, led_in, valid_cnt - v0, data_out);
      end
      tests++;
      if ({bcd_cen, bcd_dez, bcd_uni} !== 12'h123) begin
         fails++;
         $display("FAIL abort_bcd_after: bcd=%h expected 123", {bcd_cen, bcd_dez, bcd_uni});
      end
   endtask

   task automatic test_random();
      int v0, n, k, exp_disp;
      m_data = 123;
      for (int e = 0; e < 16; e++) begin
         v0 = valid_cnt;
         model_clear();
         in_req = 1'b1;
         cyc(1);
         n = $urandom_range(0, 6);
         for (int j = 0; j < n; j++) begin
            k = $urandom_range(0, 14);
            press_key(4'(k));
            model_key(k);
         end
`ifdef IO_ECHO_EN
         exp_disp = m_acc;
`else
         exp_disp = m_data;
`endif
         tests++;
         if (overflow !== m_ovf || {bcd_cen, bcd_dez, bcd_uni} !== digits(exp_disp)) begin
            fails++;
            $display("FAIL rand_entry%0d: ovf=%b bcd=%h expected %b %h", e, overflow, {bcd_cen, bcd_dez, bcd_uni}, m_ovf, digits(exp_disp));
         end
         press_key(4'hF);
         model_key(15);
         cyc(2);
         tests++;
         if (data_out !== 32'(m_data) || valid_cnt - v0 != 1) begin
            fails++;
            $display("FAIL rand_commit%0d: data_out=%0d pulses=%0d expected %0d and 1", e, data_out, valid_cnt - v0, m_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_overflow();
      test_bounce();
      test_empty_and_ignored();
      test_abort();
      test_random();
      tests++;
      if (max_run != 1) begin
         fails++;
         $display("FAIL valid_width: longest data_valid run=%0d expected 1", max_run);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
